// File: rtl/cordic_floatingpoint_pkg.sv
// Shared widths and IEEE-754 single-precision field layout for the add/sub datapath.
package cordic_floatingpoint_pkg;
    localparam int MAN_W    = 24;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int RES_W    = 1 + EXP_W + FRAC_W;
    localparam int SIGN_POS = RES_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int FRAC_LSB = 0;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    function automatic logic [RES_W-1:0] fp_pack(input logic sign,
                                                 input logic [EXP_W-1:0] exp,
                                                 input logic [FRAC_W-1:0] frac);
        logic [RES_W-1:0] r;
        r = '0;
        r[SIGN_POS] = sign;
        r[EXP_LSB +: EXP_W] = exp;
        r[FRAC_LSB +: FRAC_W] = frac;
        return r;
    endfunction
endpackage

// File: rtl/cordic_floatingpoint_addsub_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero input.
module cordic_floatingpoint_addsub_lzc24
    import cordic_floatingpoint_pkg::*;
(
    input  logic [MAN_W-1:0] a,
    output logic [4:0]       cnt
);
    always_comb begin
        cnt = 5'd24;
        // Ascending scan: the highest set bit is the last one to write cnt.
        for (int i = 0; i < MAN_W; i++) begin
            if (a[i]) cnt = 5'(MAN_W - 1 - i);
        end
    end
endmodule

// File: rtl/cordic_floatingpoint_addsub_normalizer.sv
// Post-adder normalise/round/pack: fix-up, normalise, round-and-pack stages, 3-cycle latency.
// Whole pipeline stalls together while the output is held and not accepted.
module cordic_floatingpoint_addsub_normalizer
    import cordic_floatingpoint_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [MAN_W-1:0]  iSum,
    input  logic              iCarry,
    input  logic              iEffSub,
    input  logic [EXP_W-1:0]  iExp,
    input  logic              iSign,
    output logic              oValid,
    input  logic              iReady,
    output logic [RES_W-1:0]  oResult,
    output logic              oOverflow,
    output logic              oZero
);
    logic en;
    assign en     = ~oValid | iReady;
    assign oReady = en;

    // Stage 1: carry-out renormalisation / borrow negation.
    logic              s1_vld, s1_rnd, s1_sign;
    logic [MAN_W-1:0]  s1_mant;
    logic [EXP_W:0]    s1_exp;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_vld  <= 1'b0;
            s1_rnd  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
        end else if (en) begin
            s1_vld <= iValid;
            if (!iEffSub && iCarry) begin
                s1_mant <= {1'b1, iSum[MAN_W-1:1]};
                s1_rnd  <= iSum[0];
                s1_exp  <= {1'b0, iExp} + 9'd1;
                s1_sign <= iSign;
            end else if (iEffSub && iCarry) begin
                s1_mant <= -iSum;
                s1_rnd  <= 1'b0;
                s1_exp  <= {1'b0, iExp};
                s1_sign <= ~iSign;
            end else begin
                s1_mant <= iSum;
                s1_rnd  <= 1'b0;
                s1_exp  <= {1'b0, iExp};
                s1_sign <= iSign;
            end
        end
    end

    // Stage 2: leading-zero normalisation with flush-to-zero on underflow.
    logic [4:0]        lz;
    logic [MAN_W-1:0]  norm_mant;
    logic signed [9:0] norm_exp;
    logic              mant_zero, flush;

    cordic_floatingpoint_addsub_lzc24 u_lzc (
        .a   (s1_mant),
        .cnt (lz)
    );

    assign norm_mant = s1_mant << lz;
    assign norm_exp  = $signed({1'b0, s1_exp}) - $signed({5'b0, lz});
    assign mant_zero = (s1_mant == '0);
    assign flush     = (norm_exp <= 10'sd0);

    logic              s2_vld, s2_rnd, s2_sign, s2_zero;
    logic [MAN_W-1:0]  s2_mant;
    logic [EXP_W:0]    s2_exp;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s2_vld  <= 1'b0;
            s2_rnd  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_mant <= '0;
            s2_exp  <= '0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_zero <= mant_zero | flush;
            s2_sign <= mant_zero ? 1'b0 : s1_sign;
            s2_mant <= (mant_zero | flush) ? '0 : norm_mant;
            s2_exp  <= (mant_zero | flush) ? '0 : norm_exp[EXP_W:0];
            s2_rnd  <= (mant_zero | flush) ? 1'b0 : s1_rnd;
        end
    end

    // Stage 3: ties-to-even on the single discarded bit, then pack.
    logic [MAN_W:0]    rnd_sum;
    logic [MAN_W-1:0]  fin_mant;
    logic [9:0]        fin_exp;
    logic              ovf;
    logic [RES_W-1:0]  packed_res;

    always_comb begin
        rnd_sum  = {1'b0, s2_mant} + (MAN_W+1)'(s2_rnd & s2_mant[0]);
        fin_mant = rnd_sum[MAN_W] ? 24'h800000 : rnd_sum[MAN_W-1:0];
        fin_exp  = {1'b0, s2_exp} + 10'(rnd_sum[MAN_W]);
        ovf      = ~s2_zero & (fin_exp >= 10'd255);
        if (s2_zero)
            packed_res = fp_pack(s2_sign, '0, '0);
        else if (ovf)
            packed_res = fp_pack(s2_sign, EXP_INF, '0);
        else
            packed_res = fp_pack(s2_sign, fin_exp[EXP_W-1:0], fin_mant[FRAC_W-1:0]);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid    <= 1'b0;
            oResult   <= '0;
            oOverflow <= 1'b0;
            oZero     <= 1'b0;
        end else if (en) begin
            oValid    <= s2_vld;
            oResult   <= packed_res;
            oOverflow <= ovf;
            oZero     <= s2_zero;
        end
    end
endmodule

// File: tb/tb_cordic_floatingpoint_addsub_normalizer.sv
// Directed-vector bench for the add/sub normaliser: values, latency, stall and reset.
module tb_cordic_floatingpoint_addsub_normalizer;
    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [23:0] iSum;
    logic        iCarry;
    logic        iEffSub;
    logic [7:0]  iExp;
    logic        iSign;
    logic        oValid;
    logic        iReady;
    logic [31:0] oResult;
    logic        oOverflow;
    logic        oZero;

    int checks = 0;
    int errors = 0;

    cordic_floatingpoint_addsub_normalizer dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iSum      (iSum),
        .iCarry    (iCarry),
        .iEffSub   (iEffSub),
        .iExp      (iExp),
        .iSign     (iSign),
        .oValid    (oValid),
        .iReady    (iReady),
        .oResult   (oResult),
        .oOverflow (oOverflow),
        .oZero     (oZero)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic effsub, input logic carry, input logic [23:0] sum,
                         input logic [7:0] exp, input logic sign);
        iEffSub = effsub;
        iCarry  = carry;
        iSum    = sum;
        iExp    = exp;
        iSign   = sign;
        iValid  = 1'b1;
    endtask

    // Send one operand into an empty pipeline and check result, flags and latency.
    task automatic run_vec(input string tag, input logic effsub, input logic carry,
                           input logic [23:0] sum, input logic [7:0] exp, input logic sign,
                           input logic [31:0] eres, input logic eovf, input logic ezero);
        int cyc;
        @(negedge iClk);
        drive(effsub, carry, sum, exp, sign);
        cyc = 0;
        do begin
            @(negedge iClk);
            cyc++;
            iValid = 1'b0;
        end while (!oValid && cyc < 10);
        check({tag, " latency"}, 32'(cyc), 32'd3);
        check({tag, " result"}, oResult, eres);
        check({tag, " ovf"}, {31'd0, oOverflow}, {31'd0, eovf});
        check({tag, " zero"}, {31'd0, oZero}, {31'd0, ezero});
    endtask

    logic [31:0] got_q[$];

    initial begin
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
        iSum = '0; iCarry = 1'b0; iEffSub = 1'b0; iExp = '0; iSign = 1'b0;
        #12;
        check("rst oValid", {31'd0, oValid}, 32'd0);
        check("rst oResult", oResult, 32'h0);
        check("rst flags", {30'd0, oOverflow, oZero}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        check("rst oReady", {31'd0, oReady}, 32'd1);

        run_vec("add_carry", 0, 1, 24'h000000, 8'd127, 0, 32'h40000000, 0, 0);
        run_vec("cancel",    1, 0, 24'h000001, 8'd127, 0, 32'h34000000, 0, 0);
        run_vec("flush",     1, 0, 24'h000001, 8'd10,  0, 32'h00000000, 0, 1);
        run_vec("flush_neg", 1, 0, 24'h000001, 8'd10,  1, 32'h80000000, 0, 1);
        run_vec("exact_zero",1, 0, 24'h000000, 8'd100, 1, 32'h00000000, 0, 1);
        run_vec("rnd_ovf",   0, 1, 24'hFFFFFF, 8'd127, 0, 32'h40800000, 0, 0);
        run_vec("tie_even",  0, 1, 24'h000001, 8'd127, 0, 32'h40000000, 0, 0);
        run_vec("tie_odd",   0, 1, 24'h000003, 8'd127, 0, 32'h40000002, 0, 0);
        run_vec("exp_ovf",   0, 1, 24'h000000, 8'd254, 0, 32'h7F800000, 1, 0);
        // -0xC00000 is 0x400000: one leading zero, exponent 126, sign flipped.
        run_vec("borrow",    1, 1, 24'hC00000, 8'd127, 0, 32'hBF000000, 0, 0);
        run_vec("passthru",  0, 0, 24'hC00000, 8'd100, 0, 32'h32400000, 0, 0);

        // Backpressure: three back-to-back items, stall four cycles at the first output.
        @(negedge iClk); drive(0, 1, 24'h000000, 8'd127, 0);
        @(negedge iClk); drive(1, 0, 24'h000001, 8'd127, 0);
        @(negedge iClk); drive(0, 1, 24'hFFFFFF, 8'd127, 0);
        @(negedge iClk); iValid = 1'b0;
        check("bp first valid", {31'd0, oValid}, 32'd1);
        iReady = 1'b0;
        #1;
        check("bp oReady low", {31'd0, oReady}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            check("bp hold valid", {31'd0, oValid}, 32'd1);
            check("bp hold result", oResult, 32'h40000000);
            check("bp hold oReady", {31'd0, oReady}, 32'd0);
        end
        iReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (oValid) got_q.push_back(oResult);
            @(negedge iClk);
        end
        check("bp count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("bp item0", got_q[0], 32'h40000000);
            check("bp item1", got_q[1], 32'h34000000);
            check("bp item2", got_q[2], 32'h40800000);
        end

        // Reset with items in flight.
        @(negedge iClk); drive(0, 1, 24'h000000, 8'd254, 0);
        @(negedge iClk); drive(1, 0, 24'h000001, 8'd127, 0);
        @(negedge iClk); iValid = 1'b0;
        @(negedge iClk);
        check("pre-rst valid", {31'd0, oValid}, 32'd1);
        iRst = 1'b1;
        #1;
        check("mid rst valid", {31'd0, oValid}, 32'd0);
        check("mid rst result", oResult, 32'h0);
        check("mid rst flags", {30'd0, oOverflow, oZero}, 32'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            check("post rst idle", {31'd0, oValid}, 32'd0);
        end
        run_vec("after_rst", 0, 1, 24'h000000, 8'd127, 0, 32'h40000000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
